// File: rtl/memory_map_controller_pkg.sv
// ============================================================================
// Module : memory_map_controller_pkg
// Brief  : Address map, UART constants and shared types for the controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package memory_map_controller_pkg;

  localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
  localparam logic [31:0] UART_TX_ADDR = 32'hF000_0000;
  localparam logic [31:0] MTIME_LO     = 32'hF000_0010;
  localparam logic [31:0] MTIME_HI     = 32'hF000_0014;
  localparam logic [31:0] MTIMECMP_LO  = 32'hF000_0018;
  localparam logic [31:0] MTIMECMP_HI  = 32'hF000_001C;

  localparam int UART_BAUD = 115200;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  function automatic int clks_per_bit(input int fmax_mhz);
    return (fmax_mhz * 1_000_000) / UART_BAUD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/memory_map_controller_uart_tx.sv
// ============================================================================
// Module : memory_map_controller_uart_tx
// Brief  : 8N1 LSB-first UART transmitter; busy covers start..stop bit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module memory_map_controller_uart_tx
  import memory_map_controller_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int          CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          line;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= UART_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    line      = 1'b1;
    case (state)
      UART_IDLE: begin
        if (start) begin
          state_n   = UART_START;
          cnt_n     = '0;
          bit_idx_n = '0;
          shreg_n   = data;
        end
      end
      UART_START: begin
        line = 1'b0;
        if (cnt == LAST_CNT) begin
          cnt_n   = '0;
          state_n = UART_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      UART_DATA: begin
        line = shreg[0];
        if (cnt == LAST_CNT) begin
          cnt_n   = '0;
          shreg_n = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = UART_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      UART_STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_n   = '0;
          state_n = UART_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = UART_IDLE;
    endcase
  end

  assign busy = (state != UART_IDLE);
  // Reset forces the line to idle without waiting for the clock edge.
  assign tx   = reset | line;

endmodule

`default_nettype wire

// File: rtl/memory_map_controller.sv
// ============================================================================
// Module : memory_map_controller
// Brief  : Memory-mapped slave decoding RAM, UART TX and mtimecmp accesses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module memory_map_controller
  import memory_map_controller_pkg::*;
#(
  parameter int FMAX_MHz    = 27,
  parameter int MEMORY_SIZE = 8192,
  parameter     MEMORY_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        uart_tx,
  input  logic        mem_uart_rx,
  output logic        mem_uart_tx,
  input  logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  input  logic        input_cmd_start,
  input  logic        input_cmd_write,
  output logic        output_cmd_ready,
  input  logic [31:0] input_addr,
  output logic [31:0] output_rdata,
  output logic        output_rdata_valid,
  input  logic [31:0] input_wdata
);

  localparam int CLKS_PER_BIT = clks_per_bit(FMAX_MHz);
  localparam int WORDS        = MEMORY_SIZE / 4;
  localparam int AW           = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [31:0] ram [WORDS];

  logic          accept;
  logic          rd_accept;
  logic          wr_accept;
  logic          tx_busy;
  logic          tx_start;
  logic [31:0]   word_addr;
  logic [31:0]   ram_off;
  logic          ram_hit;
  logic [AW-1:0] ram_idx;
  logic [31:0]   periph_rdata;

  logic [31:0]   ram_q;
  logic          rsp_valid;
  logic          rsp_from_ram;
  logic [31:0]   rsp_periph;
  logic [63:0]   mtimecmp_q;

  assign output_cmd_ready = !reset && !tx_busy;
  assign accept           = input_cmd_start && output_cmd_ready;
  assign rd_accept        = accept && !input_cmd_write;
  assign wr_accept        = accept && input_cmd_write;

  assign word_addr = {input_addr[31:2], 2'b00};
  assign ram_off   = word_addr - RAM_BASE;
  assign ram_hit   = (ram_off < 32'(MEMORY_SIZE));
  assign ram_idx   = ram_off[AW+1:2];
  assign tx_start  = wr_accept && (word_addr == UART_TX_ADDR);

  always_comb begin
    periph_rdata = '0;
    case (word_addr)
      UART_TX_ADDR: periph_rdata = {31'b0, tx_busy};
      MTIME_LO:     periph_rdata = mtime[31:0];
      MTIME_HI:     periph_rdata = mtime[63:32];
      MTIMECMP_LO:  periph_rdata = mtimecmp_q[31:0];
      MTIMECMP_HI:  periph_rdata = mtimecmp_q[63:32];
      default:      periph_rdata = '0;
    endcase
  end

  // RAM contents and its read register survive reset.
  always_ff @(posedge clk) begin
    if (wr_accept && ram_hit) begin
      ram[ram_idx] <= input_wdata;
    end
    if (rd_accept && ram_hit) begin
      ram_q <= ram[ram_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid    <= 1'b0;
      rsp_from_ram <= 1'b0;
      rsp_periph   <= '0;
      mtimecmp_q   <= '1;
    end else begin
      rsp_valid <= rd_accept;
      if (rd_accept) begin
        rsp_from_ram <= ram_hit;
        rsp_periph   <= ram_hit ? 32'h0 : periph_rdata;
      end
      if (wr_accept && (word_addr == MTIMECMP_LO)) begin
        mtimecmp_q[31:0] <= input_wdata;
      end
      if (wr_accept && (word_addr == MTIMECMP_HI)) begin
        mtimecmp_q[63:32] <= input_wdata;
      end
    end
  end

  assign output_rdata_valid = rsp_valid && !reset;
  assign output_rdata       = reset ? 32'h0 : (rsp_from_ram ? ram_q : rsp_periph);
  assign mtimecmp           = reset ? '1 : mtimecmp_q;
  assign mem_uart_tx        = 1'b1;

  memory_map_controller_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk  (clk),
    .reset(reset),
    .start(tx_start),
    .data (input_wdata[7:0]),
    .busy (tx_busy),
    .tx   (uart_tx)
  );

  logic unused_bits;
  assign unused_bits = ^{uart_rx, mem_uart_rx, input_addr[1:0], ram_off[31:AW+2]};

endmodule

`default_nettype wire

// File: tb/tb_memory_map_controller.sv
// ============================================================================
// Module : tb_memory_map_controller
// Brief  : Table vectors, random traffic vs. reference model, UART/reset cases.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_memory_map_controller;
  import memory_map_controller_pkg::*;

  localparam int MEM_BYTES = 8192;
  localparam int MEM_WORDS = MEM_BYTES / 4;
  localparam int CPB       = 234;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        mem_uart_rx = 1'b1;
  logic        mem_uart_tx;
  logic [63:0] mtime = '0;
  logic [63:0] mtimecmp;
  logic        input_cmd_start = 1'b0;
  logic        input_cmd_write = 1'b0;
  logic        output_cmd_ready;
  logic [31:0] input_addr = '0;
  logic [31:0] output_rdata;
  logic        output_rdata_valid;
  logic [31:0] input_wdata = '0;

  memory_map_controller #(
    .FMAX_MHz(27),
    .MEMORY_SIZE(MEM_BYTES),
    .MEMORY_FILE("")
  ) dut (
    .clk(clk),
    .reset(reset),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .mem_uart_rx(mem_uart_rx),
    .mem_uart_tx(mem_uart_tx),
    .mtime(mtime),
    .mtimecmp(mtimecmp),
    .input_cmd_start(input_cmd_start),
    .input_cmd_write(input_cmd_write),
    .output_cmd_ready(output_cmd_ready),
    .input_addr(input_addr),
    .output_rdata(output_rdata),
    .output_rdata_valid(output_rdata_valid),
    .input_wdata(input_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [63:0] mt;
    logic        exp_valid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] mem_model [MEM_WORDS];
  logic [63:0] cmp_model;
  logic [31:0] last_rdata;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [63:0] mt, input logic ev, input logic [31:0] er);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.mt = mt; v.exp_valid = ev; v.exp_rdata = er;
    return v;
  endfunction

  // Reference read: decoded purely from the address map rules.
  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [63:0] mt);
    logic [31:0] a;
    a = addr & 32'hFFFF_FFFC;
    if (a < MEM_BYTES) return mem_model[a >> 2];
    if (a == 32'hF000_0000) return 32'h0;
    if (a == 32'hF000_0010) return mt[31:0];
    if (a == 32'hF000_0014) return mt[63:32];
    if (a == 32'hF000_0018) return cmp_model[31:0];
    if (a == 32'hF000_001C) return cmp_model[63:32];
    return 32'h0;
  endfunction

  task automatic drive(input logic st, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    input_cmd_start = st;
    input_cmd_write = wr;
    input_addr      = addr;
    input_wdata     = wd;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] unm [4];
    logic        bits [10];
    logic        exp_bits [10];
    int          busy_cnt, spurious, idx;

    unm[0] = 32'hF000_0004; unm[1] = 32'hF000_0008; unm[2] = 32'hF000_0020; unm[3] = 32'h4000_0000;
    exp_bits[0] = 0; exp_bits[1] = 1; exp_bits[2] = 0; exp_bits[3] = 0; exp_bits[4] = 0;
    exp_bits[5] = 0; exp_bits[6] = 0; exp_bits[7] = 1; exp_bits[8] = 0; exp_bits[9] = 1;

    // ---------------- reset state
    repeat (3) step();
    chk("rst_ready", output_cmd_ready, 0);
    chk("rst_valid", output_rdata_valid, 0);
    chk("rst_rdata", output_rdata, 0);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_mem_uart_tx", mem_uart_tx, 1);
    chk("rst_mtimecmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", output_cmd_ready, 1);

    // ---------------- directed table, applied back-to-back
    vecs.push_back(mk(1, 32'h0000_0000, 32'h0000_0013, 64'h0, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0000, 32'h0,         64'h0, 1, 32'h0000_0013));
    vecs.push_back(mk(1, 32'h0000_0100, 32'hDEADBEEF,  64'h0, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0100, 32'h0,         64'h0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 32'h0000_0000, 32'h0,         64'h0, 1, 32'h0000_0013));
    vecs.push_back(mk(0, 32'h0000_0100, 32'h0,         64'h0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 32'h0000_0103, 32'h0,         64'h0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 32'h0000_1FFC, 32'hCAFEF00D,  64'h0, 0, 0));
    vecs.push_back(mk(1, 32'h0000_2000, 32'h1111_1111, 64'h0, 0, 0));
    vecs.push_back(mk(0, 32'h0000_1FFC, 32'h0,         64'h0, 1, 32'hCAFEF00D));
    vecs.push_back(mk(0, 32'h0000_2000, 32'h0,         64'h0, 1, 32'h0));
    vecs.push_back(mk(0, 32'h0000_0000, 32'h0,         64'h0, 1, 32'h0000_0013));
    vecs.push_back(mk(0, 32'h8000_0000, 32'h0,         64'h0, 1, 32'h0));
    vecs.push_back(mk(1, 32'hF000_0018, 32'h0000_1234, 64'h0, 0, 0));
    vecs.push_back(mk(1, 32'hF000_001C, 32'h0000_0005, 64'h0, 0, 0));
    vecs.push_back(mk(0, 32'hF000_0018, 32'h0,         64'h0, 1, 32'h0000_1234));
    vecs.push_back(mk(0, 32'hF000_001C, 32'h0,         64'h0, 1, 32'h0000_0005));
    vecs.push_back(mk(1, 32'hF000_0010, 32'hFFFF_FFFF, 64'h0000_0002_0000_0010, 0, 0));
    vecs.push_back(mk(0, 32'hF000_0010, 32'h0,         64'h0000_0002_0000_0010, 1, 32'h10));
    vecs.push_back(mk(0, 32'hF000_0014, 32'h0,         64'h0000_0002_0000_0010, 1, 32'h2));
    vecs.push_back(mk(0, 32'hF000_0000, 32'h0,         64'h0, 1, 32'h0));
    vecs.push_back(mk(0, 32'hF000_0004, 32'h0,         64'h0, 1, 32'h0));

    foreach (vecs[i]) begin
      drive(1, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      mtime = vecs[i].mt;
      step();
      chk($sformatf("vec%0d_valid", i), output_rdata_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_rdata", i), output_rdata, vecs[i].exp_rdata);
    end
    drive(0, 0, 0, 0);
    step();
    chk("mtimecmp_written", mtimecmp, 64'h0000_0005_0000_1234);

    // ---------------- rdata holds between responses
    drive(1, 0, 32'h100, 0);
    step();
    drive(0, 0, 0, 0);
    chk("hold_first_valid", output_rdata_valid, 1);
    step();
    step();
    chk("hold_valid_low", output_rdata_valid, 0);
    chk("hold_rdata", output_rdata, 32'hDEADBEEF);

    // ---------------- fill RAM with random words
    for (int w = 0; w < MEM_WORDS; w++) begin
      mem_model[w] = $urandom;
      drive(1, 1, 32'(w) << 2, mem_model[w]);
      step();
    end
    drive(0, 0, 0, 0);

    // ---------------- random traffic vs. model
    cmp_model  = 64'h0000_0005_0000_1234;
    last_rdata = 32'hDEADBEEF;
    for (int it = 0; it < 400; it++) begin
      logic        st, wr, pend;
      logic [31:0] a, wd, ed;
      int          kind;
      st   = ($urandom_range(0, 3) != 0);
      wr   = $urandom_range(0, 1);
      wd   = $urandom;
      kind = $urandom_range(0, 8);
      case (kind)
        0, 1, 2, 3: a = ($urandom_range(0, MEM_WORDS - 1) << 2) | $urandom_range(0, 3);
        4:          a = 32'h0000_2000 + $urandom_range(0, 32'h0FFF_FFFF);
        5:          a = $urandom_range(0, 1) ? 32'hF000_0014 : 32'hF000_0010;
        6:          a = $urandom_range(0, 1) ? 32'hF000_001C : 32'hF000_0018;
        7:          a = unm[$urandom_range(0, 3)];
        default: begin a = 32'hF000_0000; wr = 1'b0; end
      endcase
      mtime = {$urandom, $urandom};
      drive(st, wr, a, wd);
      pend = st && !wr;
      ed   = pend ? model_read(a, mtime) : last_rdata;
      if (st && wr) begin
        if ((a & 32'hFFFF_FFFC) < MEM_BYTES) mem_model[a >> 2] = wd;
        if ((a & 32'hFFFF_FFFC) == 32'hF000_0018) cmp_model[31:0] = wd;
        if ((a & 32'hFFFF_FFFC) == 32'hF000_001C) cmp_model[63:32] = wd;
      end
      step();
      chk($sformatf("rnd%0d_valid", it), output_rdata_valid, pend);
      chk($sformatf("rnd%0d_rdata", it), output_rdata, ed);
      chk($sformatf("rnd%0d_mtimecmp", it), mtimecmp, cmp_model);
      last_rdata = ed;
    end
    drive(0, 0, 0, 0);
    step();

    // ---------------- UART frame of 0x41, with a read held pending meanwhile
    drive(1, 1, 32'hF000_0000, 32'h41);
    step();
    drive(1, 0, 32'hF000_0000, 0);
    busy_cnt = 0; spurious = 0; idx = 0;
    foreach (bits[b]) bits[b] = 1'bx;
    while (!output_cmd_ready && idx < 5000) begin
      busy_cnt++;
      if ((idx % CPB) == CPB / 2 && (idx / CPB) < 10) bits[idx / CPB] = uart_tx;
      if (output_rdata_valid) spurious++;
      step();
      idx++;
    end
    chk("uart_busy_cycles", busy_cnt, 10 * CPB);
    chk("uart_no_resp_while_busy", spurious, 0);
    for (int b = 0; b < 10; b++) chk($sformatf("uart_bit%0d", b), bits[b], exp_bits[b]);
    chk("uart_idle_after", uart_tx, 1);
    step();
    drive(0, 0, 0, 0);
    chk("uart_read_valid", output_rdata_valid, 1);
    chk("uart_read_busy0", output_rdata, 0);

    // ---------------- reset in the cycle after a read is accepted
    step();
    drive(1, 0, 32'h100, 0);
    step();
    drive(0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("rst_mid_read_valid", output_rdata_valid, 0);
    chk("rst_mid_read_rdata", output_rdata, 0);
    chk("rst_mtimecmp_ones", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    chk("rst_mid_read_valid2", output_rdata_valid, 0);
    reset = 1'b0;
    step();
    chk("post_rst_valid", output_rdata_valid, 0);
    chk("post_rst_mtimecmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1, 0, 32'h100, 0);
    step();
    drive(0, 0, 0, 0);
    chk("ram_kept_valid", output_rdata_valid, 1);
    chk("ram_kept_rdata", output_rdata, mem_model[32'h100 >> 2]);

    // ---------------- reset aborts a UART frame
    drive(1, 1, 32'hF000_0000, 32'h00);
    step();
    drive(0, 0, 0, 0);
    repeat (100) step();
    chk("abort_start_bit_low", uart_tx, 0);
    chk("abort_ready_low", output_cmd_ready, 0);
    reset = 1'b1;
    #1;
    chk("abort_tx_high", uart_tx, 1);
    step();
    reset = 1'b0;
    #1;
    chk("abort_ready_back", output_cmd_ready, 1);
    chk("abort_tx_idle", uart_tx, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
